// File: rtl/imu_spi_master.sv
`timescale 1ns/1ps
// imu_spi_master: broadcast mode-0 SPI master for an IMU array. One command byte
// goes out on a shared MOSI, then rd_len data bytes are clocked in from every IMU's
// MISO in parallel; each completed byte column is presented on rd_data.
module imu_spi_master #(
  parameter int N_IMU   = 32,
  parameter int CLK_DIV = 4,
  parameter int MAX_RD  = 16
) (
  input  logic                                           clock,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [7:0]                                     cmd,
  input  logic [$clog2(MAX_RD+1)-1:0]                    rd_len,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           cs_n,
  output logic                                           sclk,
  output logic                                           mosi,
  input  logic [N_IMU-1:0]                               miso,
  output logic                                           byte_valid,
  output logic [((MAX_RD > 1) ? $clog2(MAX_RD) : 1)-1:0] byte_idx,
  output logic [8*N_IMU-1:0]                             rd_data
);

  localparam int LW  = $clog2(MAX_RD + 1);
  localparam int BIW = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // Bit counter must reach 8 * (MAX_RD + 1), the bit total of the longest transfer.
  localparam int BCW = $clog2(8 * (MAX_RD + 1) + 1);
  localparam int BYW = BCW - 3;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} state_e;

  state_e                  state_q, state_d;
  logic [DW-1:0]           div_q, div_d;
  logic [7:0]              tx_q, tx_d;
  logic [LW-1:0]           len_q, len_d;
  logic [BCW-1:0]          bit_q, bit_d;
  logic [N_IMU-1:0][7:0]   rx_q, rx_d, rx_shift;
  logic [8*N_IMU-1:0]      rd_data_q, rd_data_d;
  logic                    byte_valid_q, byte_valid_d;
  logic [BIW-1:0]          byte_idx_q, byte_idx_d;

  logic                    div_last;
  logic                    accept;
  logic                    sample;
  logic                    col_done;
  logic [BYW-1:0]          byte_num;
  logic [BCW-1:0]          total_bits;

  // Every non-idle state lasts exactly CLK_DIV cycles, timed by div_q.
  assign div_last   = (div_q == DW'(CLK_DIV - 1));
  assign accept     = (state_q == S_IDLE) && start;
  assign sample     = (state_q == S_HIGH) && div_last;
  assign byte_num   = bit_q[BCW-1:3];
  // Byte 0 is the command: its MISO bits are shifted but never presented.
  assign col_done   = sample && (bit_q[2:0] == 3'd7) && (byte_num != '0);
  assign total_bits = BCW'((int'(len_q) + 1) * 8);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE -> SETUP -> HIGH <-> LOW -> GAP -> IDLE.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept)   state_d = S_SETUP;
      S_SETUP: if (div_last) state_d = S_HIGH;
      S_HIGH:  if (div_last) state_d = S_LOW;
      S_LOW:   if (div_last) state_d = (bit_q == total_bits) ? S_GAP : S_HIGH;
      S_GAP:   if (div_last) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Output decode: bus pins are pure functions of state so reset clears them at once.
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_GAP) && div_last;
    cs_n = 1'b1;
    mosi = 1'b0;
    sclk = (state_q == S_HIGH);
    if (state_q inside {S_SETUP, S_HIGH, S_LOW}) begin
      cs_n = 1'b0;
      mosi = tx_q[7];
    end
  end

  // Datapath next values: divider, command shifter, bit count and byte capture.
  always_comb begin
    div_d        = (state_q != S_IDLE && !div_last) ? div_q + DW'(1) : '0;
    tx_d         = tx_q;
    len_d        = len_q;
    bit_d        = bit_q;
    rx_d         = rx_q;
    rd_data_d    = rd_data_q;
    byte_valid_d = 1'b0;
    byte_idx_d   = byte_idx_q;
    for (int i = 0; i < N_IMU; i++) rx_shift[i] = {rx_q[i][6:0], miso[i]};

    if (accept) begin
      tx_d  = cmd;
      len_d = (rd_len > LW'(MAX_RD)) ? LW'(MAX_RD) : rd_len;
      bit_d = '0;
    end
    // The shift at the end of HIGH makes the next bit appear on the first LOW cycle;
    // zeros shifted in keep MOSI low through the data bytes.
    if (sample) begin
      tx_d  = {tx_q[6:0], 1'b0};
      bit_d = bit_q + BCW'(1);
      rx_d  = rx_shift;
    end
    if (col_done) begin
      byte_valid_d = 1'b1;
      byte_idx_d   = BIW'(byte_num - BYW'(1));
      for (int i = 0; i < N_IMU; i++) rd_data_d[8*i +: 8] = rx_shift[i];
    end
  end

  // Control and output registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      tx_q         <= '0;
      len_q        <= '0;
      bit_q        <= '0;
      rd_data_q    <= '0;
      byte_valid_q <= 1'b0;
      byte_idx_q   <= '0;
    end else begin
      div_q        <= div_d;
      tx_q         <= tx_d;
      len_q        <= len_d;
      bit_q        <= bit_d;
      rd_data_q    <= rd_data_d;
      byte_valid_q <= byte_valid_d;
      byte_idx_q   <= byte_idx_d;
    end
  end

  // Per-IMU MISO shift registers.
  // NOTE: no reset here: stale bits are fully shifted out before any column is presented.
  always_ff @(posedge clock) begin
    rx_q <= rx_d;
  end

  assign rd_data    = rd_data_q;
  assign byte_valid = byte_valid_q;
  assign byte_idx   = byte_idx_q;

endmodule
